// File: rtl/count_pkg.sv
// rtl/count_pkg.sv - shared types and constants for count_generator
// Debounce FSM states, default counter geometry and Funct_Select encodings.
package count_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    PRESSED = 2'd2,
    WAIT_LO = 2'd3
  } deb_state_t;

  localparam int CNT_W       = 4;
  localparam int CNT_MAX_DEF = 9;

  localparam logic SEL_CT = 1'b0;
  localparam logic SEL_F  = 1'b1;

endpackage

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - 2-FF synchroniser, debounce FSM and press-pulse generator
// Emits one registered pulse per debounced press; holding the button yields no repeats.
module debounce_edge
  import count_pkg::*;
#(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int             TW   = $clog2(DEB_CYCLES + 1);
  localparam logic [TW-1:0]  TMAX = TW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0]  TONE = TW'(1);

  logic          r_sync1;
  logic          r_sync2;
  deb_state_t    r_state;
  logic [TW-1:0] r_timer;
  logic          r_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_state <= IDLE;
      r_timer <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_sync2) begin
            r_state <= WAIT_HI;
            r_timer <= '0;
          end
        end
        WAIT_HI: begin
          if (!r_sync2) begin
            r_state <= IDLE;
          end else if (r_timer == TMAX) begin
            r_state <= PRESSED;
            r_press <= 1'b1;
          end else begin
            r_timer <= r_timer + TONE;
          end
        end
        PRESSED: begin
          if (!r_sync2) begin
            r_state <= WAIT_LO;
            r_timer <= '0;
          end
        end
        WAIT_LO: begin
          // A bounce back high during release returns to PRESSED without a new pulse.
          if (r_sync2) begin
            r_state <= PRESSED;
          end else if (r_timer == TMAX) begin
            r_state <= IDLE;
          end else begin
            r_timer <= r_timer + TONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/count_generator.sv
// rtl/count_generator.sv - debounced up/down/clear modulo counters feeding the display FSM
// Optional macro SATURATE_EN: counters saturate at 0 / CNT_MAX instead of wrapping.
module count_generator
  import count_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int CNT_MAX    = CNT_MAX_DEF,
  parameter int WIDTH      = CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Btn_Up,
  input  logic             Btn_Down,
  input  logic             Btn_Clr,
  input  logic             Funct_Select,
  output logic [WIDTH-1:0] Count_CT,
  output logic [WIDTH-1:0] Count_F,
  output logic             Evt
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(CNT_MAX);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  logic             w_up;
  logic             w_down;
  logic             w_clr;
  logic [WIDTH-1:0] w_cur;
  logic [WIDTH-1:0] w_next;
  logic             w_chg;

  logic [WIDTH-1:0] r_cnt_ct;
  logic [WIDTH-1:0] r_cnt_f;
  logic             r_evt;

  debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
    .clk(clk), .rst(rst), .i_btn(Btn_Up), .o_press(w_up)
  );
  debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_deb_down (
    .clk(clk), .rst(rst), .i_btn(Btn_Down), .o_press(w_down)
  );
  debounce_edge #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
    .clk(clk), .rst(rst), .i_btn(Btn_Clr), .o_press(w_clr)
  );

  always_comb begin
    w_cur  = (Funct_Select == SEL_F) ? r_cnt_f : r_cnt_ct;
    w_next = w_cur;
    w_chg  = 1'b0;
    if (w_clr) begin
      // Clear always reports an event, even on a counter already at zero.
      w_next = '0;
      w_chg  = 1'b1;
    end else if (w_up && !w_down) begin
      if (w_cur > MAXV) begin
        w_next = '0;
      end else if (w_cur == MAXV) begin
`ifdef SATURATE_EN
        w_next = w_cur;
`else
        w_next = '0;
`endif
      end else begin
        w_next = w_cur + ONE;
      end
      w_chg = (w_next != w_cur);
    end else if (w_down && !w_up) begin
      if (w_cur == '0) begin
`ifdef SATURATE_EN
        w_next = '0;
`else
        w_next = MAXV;
`endif
      end else if (w_cur > MAXV) begin
        w_next = MAXV;
      end else begin
        w_next = w_cur - ONE;
      end
      w_chg = (w_next != w_cur);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt_ct <= '0;
      r_cnt_f  <= '0;
      r_evt    <= 1'b0;
    end else begin
      r_evt <= w_chg;
      if (w_chg) begin
        if (Funct_Select == SEL_F) r_cnt_f  <= w_next;
        else                       r_cnt_ct <= w_next;
      end
    end
  end

  assign Count_CT = r_cnt_ct;
  assign Count_F  = r_cnt_f;
  assign Evt      = r_evt;

endmodule
